// File: rtl/cpu_bus_pkg.sv
// ============================================================================
// | Module      : cpu_bus_pkg                                                |
// | Description : Shared types for the CPU burst bus interface: the 4-bit    |
// |               controller state encoding, the slave-mode direction        |
// |               constants and a helper classifying PC-stalling states.     |
// | Revision    : 1.0  initial release                                       |
// ============================================================================
`default_nettype none

package cpu_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_REQ       = 4'd1,
        ST_ADDR      = 4'd2,
        ST_WAIT      = 4'd3,
        ST_DATA      = 4'd4,
        ST_FINISH    = 4'd5,
        ST_S_WAIT_RD = 4'd6,
        ST_S_WAIT_WR = 4'd7,
        ST_S_RD_DATA = 4'd8,
        ST_S_WR_DATA = 4'd9,
        ST_S_FINISH  = 4'd10
    } bus_state_e;

    // Slave-mode transfer direction as seen on bus_we.
    localparam logic BUS_RD = 1'b0;
    localparam logic BUS_WR = 1'b1;

    // Master states during which the PC must be frozen.
    function automatic logic is_stall_state(input bus_state_e s);
        return (s == ST_REQ) || (s == ST_ADDR) || (s == ST_WAIT) || (s == ST_DATA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_bus_burst_if_if.sv
// ============================================================================
// | Module      : cpu_bus_burst_if_if                                        |
// | Description : Signal bundle between the CPU/bus environment and the      |
// |               burst bus controller.                                      |
// |   modport slave  : controller side (CPU/bus requests in, strobes out)    |
// |   modport master : environment side (drives requests, observes strobes)  |
// |   Requests : memop, mem_we, burst_len, cpu_halt, bus_ack, bus_wait,      |
// |              bus_we                                                      |
// |   Results  : bus_req, pc_stall, data_out, beat_strobe, beat_cnt,         |
// |              instr_addr_we, instr_addr_inc, instr_we, instr_out, bus_err |
// | Revision    : 1.0  initial release                                       |
// ============================================================================
`default_nettype none

interface cpu_bus_burst_if_if #(
    parameter int MAX_BURST = 4
) ();
    localparam int BL_W = $clog2(MAX_BURST);

    logic            memop;
    logic            mem_we;
    logic [BL_W-1:0] burst_len;
    logic            cpu_halt;
    logic            bus_ack;
    logic            bus_wait;
    logic            bus_we;

    logic            bus_req;
    logic            pc_stall;
    logic            data_out;
    logic            beat_strobe;
    logic [BL_W-1:0] beat_cnt;
    logic            instr_addr_we;
    logic            instr_addr_inc;
    logic            instr_we;
    logic            instr_out;
    logic            bus_err;

    modport slave (
        input  memop, mem_we, burst_len, cpu_halt, bus_ack, bus_wait, bus_we,
        output bus_req, pc_stall, data_out, beat_strobe, beat_cnt,
               instr_addr_we, instr_addr_inc, instr_we, instr_out, bus_err
    );

    modport master (
        output memop, mem_we, burst_len, cpu_halt, bus_ack, bus_wait, bus_we,
        input  bus_req, pc_stall, data_out, beat_strobe, beat_cnt,
               instr_addr_we, instr_addr_inc, instr_we, instr_out, bus_err
    );
endinterface

`default_nettype wire

// File: rtl/cpu_bus_beat_ctr.sv
// ============================================================================
// | Module      : cpu_bus_beat_ctr                                           |
// | Description : Master-mode datapath counters: latched request attributes, |
// |               beat index with last-beat compare and, when the            |
// |               BUS_TIMEOUT_EN macro is defined, the REQ/WAIT watchdog.    |
// |   clk, reset          : clock, asynchronous active-high reset            |
// |   i_load              : capture i_mem_we / i_burst_len                   |
// |   i_beat_inc/_clr     : advance / clear the beat index                   |
// |   i_to_clr/_run       : watchdog clear / count enable (BUS_TIMEOUT_EN)   |
// |   o_beat_cnt          : current beat index                               |
// |   o_last_beat         : current beat is the final one                    |
// |   o_timeout           : watchdog expires this cycle (BUS_TIMEOUT_EN)     |
// | Revision    : 1.0  initial release                                       |
// ============================================================================
`default_nettype none

module cpu_bus_beat_ctr #(
    parameter int BL_W        = 2
`ifdef BUS_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 255
`endif
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            i_load,
    input  wire logic            i_mem_we,
    input  wire logic [BL_W-1:0] i_burst_len,
    input  wire logic            i_beat_inc,
    input  wire logic            i_beat_clr,
`ifdef BUS_TIMEOUT_EN
    input  wire logic            i_to_clr,
    input  wire logic            i_to_run,
    output logic                 o_timeout,
`endif
    output logic [BL_W-1:0]      o_beat_cnt,
    output logic                 o_last_beat
);

    logic            r_mem_we;
    logic [BL_W-1:0] r_burst_len;
    logic [BL_W-1:0] r_beat_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_we    <= 1'b0;
            r_burst_len <= '0;
        end else if (i_load) begin
            r_mem_we    <= i_mem_we;
            r_burst_len <= i_burst_len;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_cnt <= '0;
        end else if (i_beat_clr) begin
            r_beat_cnt <= '0;
        end else if (i_beat_inc) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    assign o_beat_cnt  = r_beat_cnt;
    assign o_last_beat = (r_beat_cnt == r_burst_len);

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (i_to_clr) begin
            r_to_cnt <= '0;
        end else if (i_to_run) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // The state's first cycle sees count 0, so TIMEOUT_CYC-1 marks its final allowed cycle.
    assign o_timeout = i_to_run && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`endif

endmodule

`default_nettype wire

// File: rtl/cpu_bus_burst_if.sv
// ============================================================================
// | Module      : cpu_bus_burst_if                                           |
// | Description : CPU bus interface controller. Master mode runs a CPU       |
// |               memop as a REQ/ADDR/WAIT/DATA burst of 1..MAX_BURST beats  |
// |               with the PC stalled; slave mode (CPU halted) serves        |
// |               multi-beat instruction-memory reads/writes for another     |
// |               master. Define BUS_TIMEOUT_EN to enable the REQ/WAIT       |
// |               watchdog that aborts with a one-cycle bus_err.             |
// |   clk   : system clock, rising edge                                      |
// |   reset : asynchronous active-high reset                                 |
// |   bus   : cpu_bus_burst_if_if.slave bundle (requests in, strobes out)    |
// | Revision    : 1.0  initial release                                       |
// ============================================================================
`default_nettype none

module cpu_bus_burst_if
    import cpu_bus_pkg::*;
#(
    parameter int MAX_BURST   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic         clk,
    input  wire logic         reset,
    cpu_bus_burst_if_if.slave bus
);

    localparam int BL_W = $clog2(MAX_BURST);

    bus_state_e      r_state;
    bus_state_e      w_next;
    logic            w_load;
    logic            w_last_beat;
    logic            w_timeout;
    logic            w_abort;
    logic [BL_W-1:0] w_beat_cnt;
    logic            w_beat_strobe;
    logic            w_stall_state;
    logic            w_bus_req;
    logic            w_data_out;
    logic            w_instr_we;
    logic            w_instr_out;
    logic            w_instr_addr_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A halted CPU never starts a master transfer.
                if (bus.cpu_halt && bus.bus_ack) begin
                    w_next = (bus.bus_we == BUS_WR) ? ST_S_WAIT_WR : ST_S_WAIT_RD;
                end else if (!bus.cpu_halt && bus.memop) begin
                    w_next = ST_REQ;
                    w_load = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.bus_ack) begin
                    w_next = ST_ADDR;
                end else if (w_timeout) begin
                    w_next  = ST_FINISH;
                    w_abort = 1'b1;
                end
            end
            ST_ADDR: w_next = ST_WAIT;
            ST_WAIT: begin
                if (!bus.bus_wait) begin
                    w_next = ST_DATA;
                end else if (w_timeout) begin
                    w_next  = ST_FINISH;
                    w_abort = 1'b1;
                end
            end
            ST_DATA: begin
                if (!bus.bus_wait && w_last_beat) begin
                    w_next = ST_FINISH;
                end
            end
            ST_FINISH:    w_next = ST_IDLE;
            ST_S_WAIT_RD: w_next = ST_S_RD_DATA;
            ST_S_WAIT_WR: w_next = ST_S_WR_DATA;
            ST_S_RD_DATA,
            ST_S_WR_DATA: begin
                if (!bus.bus_ack) begin
                    w_next = ST_S_FINISH;
                end
            end
            ST_S_FINISH:  w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_bus_req        = 1'b0;
        w_data_out       = 1'b0;
        w_beat_strobe    = 1'b0;
        w_instr_we       = 1'b0;
        w_instr_out      = 1'b0;
        w_instr_addr_inc = 1'b0;
        case (r_state)
            ST_REQ, ST_ADDR: w_bus_req = 1'b1;
            ST_WAIT: begin
                w_bus_req  = 1'b1;
                w_data_out = 1'b1;
            end
            ST_DATA: begin
                w_data_out    = 1'b1;
                w_beat_strobe = !bus.bus_wait;
            end
            ST_FINISH:    w_data_out = 1'b1;
            ST_S_RD_DATA: begin
                w_instr_out      = 1'b1;
                w_instr_addr_inc = bus.bus_ack;
            end
            ST_S_WR_DATA: begin
                w_instr_we       = 1'b1;
                w_instr_addr_inc = bus.bus_ack;
            end
            default: ;
        endcase
    end

    assign w_stall_state = is_stall_state(r_state);

    cpu_bus_beat_ctr #(
        .BL_W        (BL_W)
`ifdef BUS_TIMEOUT_EN
       ,.TIMEOUT_CYC (TIMEOUT_CYC)
`endif
    ) u_beat_ctr (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_mem_we    (bus.mem_we),
        .i_burst_len (bus.burst_len),
        .i_beat_inc  (w_beat_strobe && !w_last_beat),
        .i_beat_clr  (w_next == ST_FINISH),
`ifdef BUS_TIMEOUT_EN
        // Restart the watchdog on every entry into REQ or WAIT.
        .i_to_clr    (((w_next == ST_REQ) || (w_next == ST_WAIT)) && (w_next != r_state)),
        .i_to_run    ((r_state == ST_REQ) || (r_state == ST_WAIT)),
        .o_timeout   (w_timeout),
`endif
        .o_beat_cnt  (w_beat_cnt),
        .o_last_beat (w_last_beat)
    );

`ifdef BUS_TIMEOUT_EN
    logic r_abort;

    // Remembers that FINISH was reached by a watchdog abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
        end
    end

    assign bus.bus_err = r_abort && (r_state == ST_FINISH);
`else
    assign w_timeout   = 1'b0;
    assign bus.bus_err = 1'b0;
`endif

    assign bus.bus_req        = w_bus_req;
    assign bus.pc_stall       = (bus.memop && !bus.cpu_halt && (r_state == ST_IDLE)) || w_stall_state;
    assign bus.data_out       = w_data_out;
    assign bus.beat_strobe    = w_beat_strobe;
    assign bus.beat_cnt       = w_beat_cnt;
    assign bus.instr_addr_we  = (r_state == ST_IDLE) && bus.cpu_halt && bus.bus_ack;
    assign bus.instr_addr_inc = w_instr_addr_inc;
    assign bus.instr_we       = w_instr_we;
    assign bus.instr_out      = w_instr_out;

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_burst_if.sv
// ============================================================================
// | Module      : tb_cpu_bus_burst_if                                        |
// | Description : Self-checking bench for cpu_bus_burst_if. Transactions are |
// |               described by their timing (grant delay, wait cycles per    |
// |               beat, slave beat count) and expanded into a per-cycle      |
// |               table of driven inputs and expected outputs.               |
// | Revision    : 1.0  initial release                                       |
// ============================================================================
`default_nettype none

module tb_cpu_bus_burst_if;

    localparam int BL_W = 2;

    logic clk;
    logic reset;

    cpu_bus_burst_if_if #(.MAX_BURST(4)) bif ();

    cpu_bus_burst_if #(.MAX_BURST(4), .TIMEOUT_CYC(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            memop;
        logic            mem_we;
        logic [BL_W-1:0] blen;
        logic            halt;
        logic            ack;
        logic            bwait;
        logic            we;
        logic [11:0]     exp;
    } step_t;

    step_t sched[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Output vector: req, stall, dout, strobe, cnt[1:0], addr_we, addr_inc, iwe, iout, err
    function automatic logic [11:0] ev(input logic req, input logic stall, input logic dout,
                                       input logic strobe, input logic [1:0] cnt,
                                       input logic aw, input logic ainc,
                                       input logic iwe, input logic iout);
        return {req, stall, dout, strobe, cnt, aw, ainc, iwe, iout, 1'b0};
    endfunction

    function automatic logic [11:0] sample();
        return {bif.bus_req, bif.pc_stall, bif.data_out, bif.beat_strobe, bif.beat_cnt,
                bif.instr_addr_we, bif.instr_addr_inc, bif.instr_we, bif.instr_out, bif.bus_err};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(input logic memop, input logic mwe, input logic [1:0] bl,
                                input logic halt, input logic ack, input logic bw,
                                input logic we, input logic [11:0] exp);
        step_t s;
        s.memop = memop; s.mem_we = mwe; s.blen = bl; s.halt = halt;
        s.ack = ack; s.bwait = bw; s.we = we; s.exp = exp;
        sched.push_back(s);
    endfunction

    // One master transfer: request cycle, grant after ack_d cycles, w0 initial waits,
    // wk[k] wait cycles before beat k completes, then the FINISH cycle.
    function automatic void push_master(input logic we, input logic [1:0] bl,
                                        input int ack_d, input int w0, input int wk[4]);
        add(1, we, bl, 0, 0, rb(), rb(), ev(0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < ack_d; i++)
            add(0, rb(), 2'(rb()), rb(), 0, rb(), rb(), ev(1, 1, 0, 0, 0, 0, 0, 0, 0));
        add(0, rb(), 2'(rb()), rb(), 1, rb(), rb(), ev(1, 1, 0, 0, 0, 0, 0, 0, 0));
        add(0, rb(), 2'(rb()), rb(), rb(), rb(), rb(), ev(1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < w0; i++)
            add(0, rb(), 2'(rb()), rb(), rb(), 1, rb(), ev(1, 1, 1, 0, 0, 0, 0, 0, 0));
        add(0, rb(), 2'(rb()), rb(), rb(), 0, rb(), ev(1, 1, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k <= int'(bl); k++) begin
            for (int i = 0; i < wk[k]; i++)
                add(0, rb(), 2'(rb()), rb(), rb(), 1, rb(), ev(0, 1, 1, 0, 2'(k), 0, 0, 0, 0));
            add(0, rb(), 2'(rb()), rb(), rb(), 0, rb(), ev(0, 1, 1, 1, 2'(k), 0, 0, 0, 0));
        end
        add(0, rb(), 2'(rb()), rb(), rb(), rb(), rb(), ev(0, 0, 1, 0, 0, 0, 0, 0, 0));
    endfunction

    // One slave transfer of n data beats; bus_ack stays high for all but the last beat.
    function automatic void push_slave(input logic we, input int n);
        add(rb(), rb(), 2'(rb()), 1, 1, rb(), we, ev(0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(rb(), rb(), 2'(rb()), 1, rb(), rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < n; i++) begin
            logic a;
            a = (i < n - 1);
            add(rb(), rb(), 2'(rb()), 1, a, rb(), rb(), ev(0, 0, 0, 0, 0, 0, a, we, !we));
        end
        add(rb(), rb(), 2'(rb()), 1, 0, rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    // Idle cycles that must not start anything.
    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) begin
            logic h;
            h = rb();
            add(h ? rb() : 1'b0, rb(), 2'(rb()), h, h ? 1'b0 : rb(), rb(), rb(),
                ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endfunction

    task automatic drive(input step_t s);
        bif.memop = s.memop; bif.mem_we = s.mem_we; bif.burst_len = s.blen;
        bif.cpu_halt = s.halt; bif.bus_ack = s.ack; bif.bus_wait = s.bwait; bif.bus_we = s.we;
    endtask

    task automatic drive_zero();
        bif.memop = 0; bif.mem_we = 0; bif.burst_len = '0; bif.cpu_halt = 0;
        bif.bus_ack = 0; bif.bus_wait = 0; bif.bus_we = 0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        drive_zero();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 got = sample();
        n_checks++;
        if (got !== 12'h000) $display("FAIL reset_hold got %b exp %b", got, 12'h000);
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        #1 got = sample();
        n_checks++;
        if (got !== 12'h000) $display("FAIL reset_idle got %b exp %b", got, 12'h000);
        else n_pass++;
    endtask

    task automatic test_single_load();
        logic [11:0] got;
        sched.delete();
        push_master(0, 2'd0, 2, 0, '{0, 0, 0, 0});
        push_idle(1);
        foreach (sched[i]) begin
            @(negedge clk);
            drive(sched[i]);
            #1 got = sample();
            n_checks++;
            if (got !== sched[i].exp) $display("FAIL single_load step %0d got %b exp %b", i, got, sched[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_burst_wait();
        logic [11:0] got;
        int strobes;
        strobes = 0;
        sched.delete();
        push_master(1, 2'd3, 0, 1, '{0, 2, 0, 0});
        push_idle(1);
        foreach (sched[i]) begin
            @(negedge clk);
            drive(sched[i]);
            #1 got = sample();
            if (bif.beat_strobe === 1'b1) strobes++;
            n_checks++;
            if (got !== sched[i].exp) $display("FAIL burst_wait step %0d got %b exp %b", i, got, sched[i].exp);
            else n_pass++;
        end
        n_checks++;
        if (strobes !== 4) $display("FAIL burst_strobes got %0d exp %0d", strobes, 4);
        else n_pass++;
    endtask

    task automatic test_slave_write();
        logic [11:0] got;
        sched.delete();
        push_slave(1, 3);
        push_idle(1);
        foreach (sched[i]) begin
            @(negedge clk);
            drive(sched[i]);
            #1 got = sample();
            n_checks++;
            if (got !== sched[i].exp) $display("FAIL slave_write step %0d got %b exp %b", i, got, sched[i].exp);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        logic [11:0] got;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_zero();
            bif.cpu_halt = 1; bif.memop = 1; bif.bus_wait = rb(); bif.bus_we = rb();
            #1 got = sample();
            n_checks++;
            if (got !== 12'h000) $display("FAIL priority cyc %0d got %b exp %b", i, got, 12'h000);
            else n_pass++;
        end
        @(negedge clk);
        drive_zero();
        #1 got = sample();
        n_checks++;
        if (got !== 12'h000) $display("FAIL priority_after got %b exp %b", got, 12'h000);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [11:0] got;
        for (int t = 0; t < 40; t++) begin
            int kind;
            sched.delete();
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                push_master(rb(), 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 2),
                            '{$urandom_range(0, 2), $urandom_range(0, 2),
                              $urandom_range(0, 2), $urandom_range(0, 2)});
            end else if (kind == 1) begin
                push_slave(rb(), $urandom_range(1, 4));
            end else begin
                push_idle($urandom_range(1, 3));
            end
            foreach (sched[i]) begin
                @(negedge clk);
                drive(sched[i]);
                #1 got = sample();
                n_checks++;
                if (got !== sched[i].exp) $display("FAIL random t%0d step %0d got %b exp %b", t, i, got, sched[i].exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] got;
        sched.delete();
        push_master(0, 2'd1, 0, 5, '{0, 0, 0, 0});
        // Steps 0..4: request, REQ, ADDR and two WAIT cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(sched[i]);
            #1 got = sample();
            n_checks++;
            if (got !== sched[i].exp) $display("FAIL areset_pre step %0d got %b exp %b", i, got, sched[i].exp);
            else n_pass++;
        end
        #2;
        drive_zero();
        reset = 1'b1;
        #1 got = sample();
        n_checks++;
        if (got !== 12'h000) $display("FAIL areset_immediate got %b exp %b", got, 12'h000);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        sched.delete();
        push_master(1, 2'($urandom_range(0, 3)), $urandom_range(0, 2), 0, '{1, 0, 1, 0});
        push_idle(1);
        foreach (sched[i]) begin
            @(negedge clk);
            drive(sched[i]);
            #1 got = sample();
            n_checks++;
            if (got !== sched[i].exp) $display("FAIL areset_post step %0d got %b exp %b", i, got, sched[i].exp);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive_zero();
        test_reset();
        test_single_load();
        test_burst_wait();
        test_slave_write();
        test_priority();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
